// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions, datapath width and
// the register-file clear/ready state encoding.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;

    localparam logic [0:0] RF_CLEAR = 1'b0;
    localparam logic [0:0] RF_READY = 1'b1;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    function automatic reg_idx_t getRs1(input logic [XLEN-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic reg_idx_t getRs2(input logic [XLEN-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    function automatic reg_idx_t getRd(input logic [XLEN-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, emitting a
// zero-write per cycle, then parks in READY until the next reset.
module regfile_clear_seq
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
        end else if (r_state == RF_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == LAST_IDX) begin
                r_state <= RF_READY;
            end
        end
    end

    assign clr_we   = (r_state == RF_CLEAR);
    assign clr_addr = r_clr_idx;
    assign ready    = (r_state == RF_READY);

endmodule

// File: rtl/regfile_multiport.sv
// Two-read / one-write register file with hardwired-zero x0, write-first
// bypass and registered read outputs, gated by the clear sequencer.
module regfile_multiport
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   instruction,
    input  logic              instr_valid,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              rd_valid,
    output logic              ready
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_read_data_1;
    logic [DATA_W-1:0] r_read_data_2;
    logic              r_rd_valid;

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;
    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic              w_wb_ok;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_unused_instr;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .ready    (w_ready)
    );

    assign w_rs1          = getRs1(instruction);
    assign w_rs2          = getRs2(instruction);
    assign w_unused_instr = ^{instruction[31:25], instruction[14:0]};

    assign w_wb_ok = w_ready && wb_en && (wb_addr != '0) && ({1'b0, wb_addr} < DEPTH_EXT);

    // x0 and out-of-range indices read as zero; a same-cycle write to the index wins.
    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
        if (idx == '0 || {1'b0, idx} >= DEPTH_EXT) begin
            return '0;
        end else if (wb_en && wb_addr == idx) begin
            return wb_data;
        end
        return r_mem[idx[IDX_W-1:0]];
    endfunction

    always_comb begin
        w_rd1 = readPort(w_rs1);
        w_rd2 = readPort(w_rs2);
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr[IDX_W-1:0]] <= '0;
        end else if (w_wb_ok) begin
            r_mem[wb_addr[IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data_1 <= '0;
            r_read_data_2 <= '0;
            r_rd_valid    <= 1'b0;
        end else if (w_ready && instr_valid) begin
            r_read_data_1 <= w_rd1;
            r_read_data_2 <= w_rd2;
            r_rd_valid    <= 1'b1;
        end else begin
            r_rd_valid    <= 1'b0;
        end
    end

    assign read_data_1 = r_read_data_1;
    assign read_data_2 = r_read_data_2;
    assign rd_valid    = r_rd_valid;
    assign ready       = w_ready;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a DEPTH=32 instance (A) and a
// DEPTH=16 instance (B), each with its own reference model and scoreboard.
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] instrA, wbDataA, rdData1A, rdData2A;
    logic [4:0]  wbAddrA;
    logic        ivA, wbEnA, rdValidA, readyA;

    logic [31:0] instrB, wbDataB, rdData1B, rdData2B;
    logic [4:0]  wbAddrB;
    logic        ivB, wbEnB, rdValidB, readyB;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelA [32];
    logic [31:0] modelB [16];
    logic        modelReadyA = 1'b0;
    logic        modelReadyB = 1'b0;
    logic [63:0] expQA [$];
    logic [63:0] expQB [$];

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(32), .DEPTH(32), .ADDR_W(5)) dutA (
        .clk(clk), .rst(rst), .instruction(instrA), .instr_valid(ivA),
        .wb_en(wbEnA), .wb_addr(wbAddrA), .wb_data(wbDataA),
        .read_data_1(rdData1A), .read_data_2(rdData2A),
        .rd_valid(rdValidA), .ready(readyA)
    );

    regfile_multiport #(.DATA_W(32), .DEPTH(16), .ADDR_W(5)) dutB (
        .clk(clk), .rst(rst), .instruction(instrB), .instr_valid(ivB),
        .wb_en(wbEnB), .wb_addr(wbAddrB), .wb_data(wbDataB),
        .read_data_1(rdData1B), .read_data_2(rdData2B),
        .rd_valid(rdValidB), .ready(readyB)
    );

    // Scoreboard: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rdValidA === 1'b1) begin
            checks++;
            if (expQA.size() == 0) begin
                errors++;
                $display("[TB] FAIL sbA_unexpected rd_valid got 1 required 0 (no read pending)");
            end else begin
                logic [63:0] e;
                e = expQA.pop_front();
                if ({rdData1A, rdData2A} !== e) begin
                    errors++;
                    $display("[TB] FAIL sbA_data got %h/%h required %h/%h", rdData1A, rdData2A, e[63:32], e[31:0]);
                end
            end
        end
        if (rdValidB === 1'b1) begin
            checks++;
            if (expQB.size() == 0) begin
                errors++;
                $display("[TB] FAIL sbB_unexpected rd_valid got 1 required 0 (no read pending)");
            end else begin
                logic [63:0] e;
                e = expQB.pop_front();
                if ({rdData1B, rdData2B} !== e) begin
                    errors++;
                    $display("[TB] FAIL sbB_data got %h/%h required %h/%h", rdData1B, rdData2B, e[63:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] modelRead(input int sel, input logic [4:0] idx,
                                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
        int depth;
        depth = (sel == 0) ? 32 : 16;
        if (idx == 5'd0 || int'(idx) >= depth) return 32'h0;
        if (we && wa == idx) return wd;
        return (sel == 0) ? modelA[idx] : modelB[idx[3:0]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModels();
        for (int i = 0; i < 32; i++) modelA[i] = 32'h0;
        for (int i = 0; i < 16; i++) modelB[i] = 32'h0;
    endtask

    // Drives one cycle of stimulus into instance sel, updating model and scoreboard.
    task automatic applyStimulus(input int sel, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [4:0] s1, input logic [4:0] s2);
        logic [31:0] e1, e2, ins;
        ins = {7'h00, s2, s1, 3'b000, 5'd1, 7'h33};
        e1  = modelRead(sel, s1, we, wa, wd);
        e2  = modelRead(sel, s2, we, wa, wd);
        if (sel == 0) begin
            wbEnA = we; wbAddrA = wa; wbDataA = wd; ivA = iv; instrA = ins;
            if (modelReadyA && iv) expQA.push_back({e1, e2});
            if (modelReadyA && we && wa != 5'd0) modelA[wa] = wd;
        end else begin
            wbEnB = we; wbAddrB = wa; wbDataB = wd; ivB = iv; instrB = ins;
            if (modelReadyB && iv) expQB.push_back({e1, e2});
            if (modelReadyB && we && wa != 5'd0 && wa < 5'd16) modelB[wa[3:0]] = wd;
        end
        step();
        wbEnA = 1'b0; ivA = 1'b0; wbEnB = 1'b0; ivB = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({readyA, rdValidA, readyB, rdValidB} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b required 0000", {readyA, rdValidA, readyB, rdValidB});
        end
        checks++;
        if ({rdData1A, rdData2A} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h/%h required 0/0", rdData1A, rdData2A);
        end
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (readyA !== (k >= 32)) begin
                errors++;
                $display("[TB] FAIL clear_readyA cycle=%0d got %b required %b", k, readyA, (k >= 32));
            end
            checks++;
            if (readyB !== (k >= 16)) begin
                errors++;
                $display("[TB] FAIL clear_readyB cycle=%0d got %b required %b", k, readyB, (k >= 16));
            end
        end
        clearModels();
        modelReadyA = 1'b1;
        modelReadyB = 1'b1;
        for (int r = 0; r < 32; r++) begin
            applyStimulus(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'(31 - r));
        end
    endtask

    task automatic test_write_read();
        applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        applyStimulus(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
        checks++;
        if (rdValidA !== 1'b1 || rdData1A !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_read got valid=%b data=%h required valid=1 data=deadbeef", rdValidA, rdData1A);
        end
        step();
        checks++;
        if (rdValidA !== 1'b0 || rdData1A !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_hold got valid=%b data=%h required valid=0 data=deadbeef", rdValidA, rdData1A);
        end
    endtask

    task automatic test_x0();
        applyStimulus(0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        applyStimulus(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        checks++;
        if ({rdData1A, rdData2A} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL x0_read got %h/%h required 0/0", rdData1A, rdData2A);
        end
        applyStimulus(0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    endtask

    task automatic test_bypass();
        applyStimulus(0, 1'b1, 5'd7, 32'h00001234, 1'b1, 5'd7, 5'd7);
        checks++;
        if ({rdData1A, rdData2A} !== {32'h1234, 32'h1234}) begin
            errors++;
            $display("[TB] FAIL bypass got %h/%h required 00001234/00001234", rdData1A, rdData2A);
        end
        applyStimulus(0, 1'b1, 5'd9, 32'h0BADF00D, 1'b1, 5'd7, 5'd9);
        applyStimulus(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_depth16();
        applyStimulus(1, 1'b1, 5'd4,  32'h44444444, 1'b0, 5'd0, 5'd0);
        applyStimulus(1, 1'b1, 5'd15, 32'hAAAA0001, 1'b0, 5'd0, 5'd0);
        applyStimulus(1, 1'b1, 5'd15, 32'hBBBB0002, 1'b0, 5'd0, 5'd0);
        applyStimulus(1, 1'b1, 5'd20, 32'hCCCC0003, 1'b0, 5'd0, 5'd0);
        applyStimulus(1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 5'd15);
        checks++;
        if ({rdData1B, rdData2B} !== {32'h0, 32'hBBBB0002}) begin
            errors++;
            $display("[TB] FAIL depth16_range got %h/%h required 00000000/bbbb0002", rdData1B, rdData2B);
        end
        applyStimulus(1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd31);
        checks++;
        if ({rdData1B, rdData2B} !== {32'h44444444, 32'h0}) begin
            errors++;
            $display("[TB] FAIL depth16_alias got %h/%h required 44444444/00000000", rdData1B, rdData2B);
        end
        applyStimulus(1, 1'b1, 5'd20, 32'h12345678, 1'b1, 5'd20, 5'd20);
    endtask

    task automatic test_reset_mid_clear();
        modelReadyA = 1'b0;
        modelReadyB = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 5'd3, 32'h55AA55AA, 1'b1, 5'd3, 5'd3);
        for (int k = 2; k <= 32; k++) begin
            applyStimulus(0, 1'b1, 5'd3, 32'h55AA55AA, 1'b1, 5'd3, 5'd5);
            if (k >= 30) begin
                checks++;
                if (readyA !== (k >= 32)) begin
                    errors++;
                    $display("[TB] FAIL restart_ready cycle=%0d got %b required %b", k, readyA, (k >= 32));
                end
            end
        end
        clearModels();
        modelReadyA = 1'b1;
        modelReadyB = 1'b1;
        applyStimulus(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5);
        checks++;
        if ({rdData1A, rdData2A} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL restart_cleared got %h/%h required 0/0", rdData1A, rdData2A);
        end
    endtask

    initial begin
        rst = 1'b1;
        instrA = '0; wbDataA = '0; wbAddrA = '0; ivA = 1'b0; wbEnA = 1'b0;
        instrB = '0; wbDataB = '0; wbAddrB = '0; ivB = 1'b0; wbEnB = 1'b0;
        clearModels();
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_depth16();
        test_reset_mid_clear();
        step();
        step();
        checks++;
        if (expQA.size() != 0 || expQB.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain got %0d/%0d pending required 0/0", expQA.size(), expQB.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
